// File: rtl/mem_bist.sv
// Purpose : March-style memory BIST engine. Writes a seed-based pattern across
//           DEPTH locations and reads it back, then repeats with the pattern
//           inverted. Mismatches are counted and the first one is logged.
// Latency : start sampled in IDLE -> WR0 next cycle; done pulses 4*DEPTH+3
//           cycles after the accepted start (67 for DEPTH=16).
// Backpressure: none. The memory must accept one strobe per cycle and return
//           read data one cycle after the read edge.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, abort      run request (IDLE only) / cancel a run in progress
//   seed              pattern base, captured on an accepted start
//   mem_write/read    memory strobes (never both high)
//   mem_addr/wdata    memory address and write data
//   mem_rdata         memory read data, valid one cycle after mem_read
//   busy, done, pass  run status; done is a one-cycle pulse in FIN
//   fail_addr/data    address and observed data of the first mismatch
//   err_count         mismatch count, saturating at 31
module mem_bist #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] seed,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [4:0]        err_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    RD0  = 3'd2,
    DRN0 = 3'd3,
    WR1  = 3'd4,
    RD1  = 3'd5,
    DRN1 = 3'd6,
    FIN  = 3'd7
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [4:0]        ERR_MAX   = 5'd31;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   seed_q, seed_d;

  // Read-compare pipeline: a read issued this cycle is checked next cycle
  // against the pattern of the address it was issued to.
  logic                rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_inv_q, rd_inv_d;

  logic [4:0]          err_q, err_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;
  logic                pass_q, pass_d;

  logic                last_addr;
  logic                busy_c;
  logic                mismatch;
  logic [DATA_W-1:0]   rd_expect;

  // Pattern = (base + addr) mod 2**DATA_W, optionally inverted.
  function automatic logic [DATA_W-1:0] pattern(
    input logic [DATA_W-1:0] base,
    input logic [ADDR_W-1:0] a,
    input logic              inv
  );
    logic [DATA_W-1:0] p;
    p = base + DATA_W'(a);
    return inv ? ~p : p;
  endfunction

  assign last_addr = (addr_q == LAST_ADDR);
  assign busy_c    = (state_q == WR0) || (state_q == RD0) || (state_q == DRN0) ||
                     (state_q == WR1) || (state_q == RD1) || (state_q == DRN1);
  assign rd_expect = pattern(seed_q, rd_addr_q, rd_inv_q);
  assign mismatch  = rd_pend_q && (mem_rdata != rd_expect);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      seed_q      <= '0;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_inv_q    <= 1'b0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      seed_q      <= seed_d;
      rd_pend_q   <= rd_pend_d;
      rd_addr_q   <= rd_addr_d;
      rd_inv_q    <= rd_inv_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      pass_q      <= pass_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    seed_d      = seed_q;
    rd_pend_d   = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_inv_d    = rd_inv_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    pass_d      = pass_q;

    mem_write   = 1'b0;
    mem_read    = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    done        = 1'b0;

    // Compare is evaluated before the state decode so a mismatch on the
    // final read (checked in DRN1) is already in err_d when pass is set.
    if (mismatch) begin
      if (err_q != ERR_MAX) begin
        err_d = err_q + 5'd1;
      end
      // err_q only grows within a run, so zero means this is the first miss.
      if (err_q == 5'd0) begin
        fail_addr_d = rd_addr_q;
        fail_data_d = mem_rdata;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WR0;
          seed_d      = seed;
          addr_d      = '0;
          err_d       = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          pass_d      = 1'b0;
        end
      end

      WR0, WR1: begin
        mem_write = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = pattern(seed_q, addr_q, state_q == WR1);
        if (last_addr) begin
          addr_d  = '0;
          state_d = (state_q == WR0) ? RD0 : RD1;
        end else begin
          addr_d  = addr_q + 1'b1;
        end
      end

      RD0, RD1: begin
        mem_read  = 1'b1;
        mem_addr  = addr_q;
        rd_pend_d = 1'b1;
        rd_addr_d = addr_q;
        rd_inv_d  = (state_q == RD1);
        if (last_addr) begin
          addr_d  = '0;
          state_d = (state_q == RD0) ? DRN0 : DRN1;
        end else begin
          addr_d  = addr_q + 1'b1;
        end
      end

      DRN0: begin
        state_d = WR1;
      end

      DRN1: begin
        state_d = FIN;
        pass_d  = (err_d == 5'd0);
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything in a busy state; strobes issued this cycle
    // still complete, but their compare is dropped.
    if (busy_c && abort) begin
      state_d   = IDLE;
      addr_d    = '0;
      rd_pend_d = 1'b0;
      pass_d    = 1'b0;
    end
  end

  assign busy      = busy_c;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: a behavioural 16x8 memory with injectable faults, a
// scoreboard of expected writes/reads/done results/busy lengths filled by the
// stimulus, and a negedge monitor that pops and compares on DUT activity.
module tb_mem_bist;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] seed;
  logic       mem_write;
  logic       mem_read;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_addr;
  logic [7:0] fail_data;
  logic [4:0] err_count;

  mem_bist #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model. fault: 0 ideal, 1 bit0 stuck-at-0 at addr 5, 2 reads 0x00.
  int         fault = 0;
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= (fault == 1 && mem_addr == 4'd5) ? (mem_wdata & 8'hFE) : mem_wdata;
    if (mem_read)  mem_rdata     <= (fault == 2) ? 8'h00 : mem[mem_addr];
  end

  typedef struct packed {logic [3:0] a; logic [7:0] d;} acc_t;
  typedef struct {logic p; logic [4:0] e; logic [3:0] fa; logic [7:0] fd; int c;} done_t;

  acc_t  wr_q[$];
  acc_t  rd_q[$];
  done_t done_q[$];
  int    busy_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  acc_t  wexp;
  acc_t  rexp;
  done_t dexp;
  logic  busy_prev = 1'b0;
  int    busy_cnt  = 0;
  int    bexp;
  always @(negedge clk) begin
    if (mem_write === 1'b1 || mem_read === 1'b1)
      chk("strobe_exclusive", {mem_write, mem_read} == 2'b11, 0);
    if (mem_write === 1'b1) begin
      if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        wexp = wr_q.pop_front();
        chk("wr_addr", mem_addr, wexp.a);
        chk("wr_data", mem_wdata, wexp.d);
      end
    end
    if (mem_read === 1'b1) begin
      if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
      else begin
        rexp = rd_q.pop_front();
        chk("rd_addr", mem_addr, rexp.a);
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        dexp = done_q.pop_front();
        chk("done_cycle", cyc, dexp.c);
        chk("done_pass", pass, dexp.p);
        chk("done_err_count", err_count, dexp.e);
        chk("done_fail_addr", fail_addr, dexp.fa);
        chk("done_fail_data", fail_data, dexp.fd);
        chk("done_busy_low", busy, 0);
      end
    end
    if (busy === 1'b1) busy_cnt++;
    else if (busy_prev) begin
      if (busy_q.size() == 0) chk("unexpected_busy_fall", 1, 0);
      else begin
        bexp = busy_q.pop_front();
        chk("busy_cycles", busy_cnt, bexp);
      end
      busy_cnt = 0;
    end
    busy_prev = (busy === 1'b1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected strobe sequence: WR0 addr 0..15, then WR1 with inverted data.
  task automatic push_exp(input logic [7:0] s, input int n_wr, input int n_rd, input int blen);
    acc_t e;
    for (int i = 0; i < n_wr; i++) begin
      e.a = 4'(i % 16);
      e.d = s + 8'(i % 16);
      if (i >= 16) e.d = ~e.d;
      wr_q.push_back(e);
    end
    for (int i = 0; i < n_rd; i++) begin
      e.a = 4'(i % 16);
      e.d = 8'h00;
      rd_q.push_back(e);
    end
    busy_q.push_back(blen);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {busy, done, pass, mem_write, mem_read, mem_addr, mem_wdata,
               err_count, fail_addr, fail_data}, 0);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_wr_q_empty"}, wr_q.size(), 0);
    chk({tag, "_rd_q_empty"}, rd_q.size(), 0);
    chk({tag, "_done_q_empty"}, done_q.size(), 0);
    chk({tag, "_busy_q_empty"}, busy_q.size(), 0);
  endtask

  // Full run; extra>0 pulses a second (ignored) start that many cycles in.
  task automatic run(input logic [7:0] s, input int flt, input int extra,
                     input logic ep, input logic [4:0] ee,
                     input logic [3:0] efa, input logic [7:0] efd);
    done_t d;
    bit    fin;
    fault = flt;
    push_exp(s, 32, 32, 66);
    d.p = ep; d.e = ee; d.fa = efa; d.fd = efd; d.c = cyc + 67;
    done_q.push_back(d);
    seed  = s;
    start = 1'b1;
    fin   = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      tick;
      start = (k == extra);
      seed  = (k == extra) ? 8'h33 : ~s;
      if (k > 67 && done_q.size() == 0 && busy === 1'b0) begin
        fin = 1'b1;
        break;
      end
    end
    chk("run_completed", fin, 1);
    repeat (3) tick;
    chk("hold_pass", pass, ep);
    chk("hold_err_count", err_count, ee);
    chk("hold_fail_addr", fail_addr, efa);
    chk("hold_fail_data", fail_data, efd);
    chk("hold_done_low", done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    start = 1'b0;
    abort = 1'b0;
    seed  = 8'h00;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    chk_all_zero("idle_after_reset");

    run(8'h00, 0, 0, 1'b1, 5'd0,  4'd0, 8'h00);  // ideal, addr3: 0x03 / 0xFC
    run(8'h00, 1, 0, 1'b0, 5'd1,  4'd5, 8'h04);  // stuck bit0 at addr 5
    run(8'hF8, 0, 0, 1'b1, 5'd0,  4'd0, 8'h00);  // addr15: 0x07 / 0xF8
    run(8'h01, 2, 0, 1'b0, 5'd31, 4'd0, 8'h00);  // 32 misses, saturates
    run(8'h5A, 0, 10, 1'b1, 5'd0, 4'd0, 8'h00);  // second start ignored
    chk_drained("runs");

    // Abort in cycle 30 (RD0 addr 13): 16 writes, reads 0..13, busy 30.
    fault = 0;
    push_exp(8'h10, 16, 14, 30);
    seed  = 8'h10;
    start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick;
      start = 1'b0;
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_strobes", {mem_write, mem_read}, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    repeat (5) tick;
    chk("abort_stays_idle", busy, 0);
    chk_drained("abort");

    // Reset in cycle 20 (RD0 addr 3): 16 writes, reads 0..2, busy 19.
    push_exp(8'h00, 16, 3, 19);
    seed  = 8'h00;
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1 chk_all_zero("midrun_reset_async");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    chk_all_zero("midrun_reset_idle");
    chk_drained("reset");

    run(8'h00, 0, 0, 1'b1, 5'd0, 4'd0, 8'h00);   // normal run after reset
    chk_drained("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
